// File: rtl/display_arbiter.sv
// Arbitrates the 4-digit seven-segment datapath between countdown, programming and done-alert sources.
// Optional macro DISP_ARB_TIMEOUT_EN adds an auto-clear of the alert after ALERT_TIMEOUT ticks.
//
// state  | meaning
// S_IDLE | nobody owns the display; dark, digits 0
// S_COUNT| countdown digits shown
// S_PROG | cook-time programming digits shown
// S_ALERT| alert pattern shown, blinking until ack (or timeout)
module display_arbiter #(
  parameter int HOLD_TICKS    = 50,
  parameter int BLINK_TICKS   = 25,
  parameter int ALERT_TIMEOUT = 6000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        count_req,
  input  logic [15:0] count_digits,
  input  logic        prog_req,
  input  logic [15:0] prog_digits,
  input  logic        alert_req,
  input  logic [15:0] alert_digits,
  input  logic        alert_ack,
  output logic [15:0] digits,
  output logic        blank,
  output logic [2:0]  grant,
  output logic        alert_timeout
);

  localparam int HOLD_W  = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_PROG, S_ALERT} state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [BLINK_W-1:0]  blink_cnt, blink_nxt;
  logic [15:0]         digits_nxt;
  logic [2:0]          grant_nxt;
  logic                blank_nxt;
  logic                alert_req_q;
  logic                alert_pending;
  logic                alert_rise;
  logic                timeout_hit;
  logic                alert_entry;
  logic                hold_entry;

  assign alert_rise  = alert_req & ~alert_req_q;
  assign alert_entry = (state_nxt == S_ALERT) && (state != S_ALERT);
  assign hold_entry  = ((state_nxt == S_COUNT) || (state_nxt == S_PROG)) && (state_nxt != state);

`ifdef DISP_ARB_TIMEOUT_EN
  localparam int ALERT_W = $clog2(ALERT_TIMEOUT + 1);
  logic [ALERT_W-1:0] alert_cnt;
  logic               alert_timeout_q;

  // Ack in the same cycle as the timeout wins and suppresses the pulse.
  assign timeout_hit = (state == S_ALERT) && alert_pending && !alert_ack &&
                       (alert_cnt == ALERT_W'(ALERT_TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alert_cnt       <= '0;
      alert_timeout_q <= 1'b0;
    end else begin
      alert_timeout_q <= timeout_hit;
      if (alert_entry)
        alert_cnt <= '0;
      else if ((state == S_ALERT) && tick && (alert_cnt != ALERT_W'(ALERT_TIMEOUT)))
        alert_cnt <= alert_cnt + 1'b1;
    end
  end

  assign alert_timeout = alert_timeout_q;
`else
  assign timeout_hit   = 1'b0;
  assign alert_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alert_req_q   <= 1'b0;
      alert_pending <= 1'b0;
    end else begin
      alert_req_q <= alert_req;
      if (alert_ack || timeout_hit)
        alert_pending <= 1'b0;
      else if (alert_rise)
        alert_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (alert_pending)  state_nxt = S_ALERT;
        else if (prog_req)  state_nxt = S_PROG;
        else if (count_req) state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (alert_pending)                       state_nxt = S_ALERT;
        else if (hold_cnt == '0 && prog_req)     state_nxt = S_PROG;
        else if (hold_cnt == '0 && !count_req)   state_nxt = S_IDLE;
      end
      S_PROG: begin
        // count_req never preempts programming
        if (alert_pending)                       state_nxt = S_ALERT;
        else if (hold_cnt == '0 && !prog_req)    state_nxt = count_req ? S_COUNT : S_IDLE;
      end
      S_ALERT: begin
        if (!alert_pending) begin
          if (prog_req)       state_nxt = S_PROG;
          else if (count_req) state_nxt = S_COUNT;
          else                state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hold_nxt  = hold_cnt;
    blink_nxt = blink_cnt;
    blank_nxt = blank;
    grant_nxt = 3'b000;

    // Digits follow the source owning the display this cycle, so they trail grant by one clock.
    unique case (state)
      S_COUNT: digits_nxt = count_digits;
      S_PROG:  digits_nxt = prog_digits;
      S_ALERT: digits_nxt = alert_digits;
      default: digits_nxt = 16'h0000;
    endcase

    if (hold_entry)
      hold_nxt = HOLD_W'(HOLD_TICKS);
    else if (tick && (hold_cnt != '0))
      hold_nxt = hold_cnt - 1'b1;

    if (alert_entry) begin
      blink_nxt = '0;
      blank_nxt = 1'b0;
    end else if ((state == S_ALERT) && tick) begin
      if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_nxt = '0;
        blank_nxt = ~blank;
      end else begin
        blink_nxt = blink_cnt + 1'b1;
      end
    end

    unique case (state_nxt)
      S_IDLE: begin
        grant_nxt = 3'b000;
        blank_nxt = 1'b1;
      end
      S_COUNT: begin
        grant_nxt = 3'b001;
        blank_nxt = 1'b0;
      end
      S_PROG: begin
        grant_nxt = 3'b010;
        blank_nxt = 1'b0;
      end
      S_ALERT: grant_nxt = 3'b100;
      default: grant_nxt = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      blink_cnt <= '0;
      digits    <= 16'h0000;
      blank     <= 1'b1;
      grant     <= 3'b000;
    end else begin
      hold_cnt  <= hold_nxt;
      blink_cnt <= blink_nxt;
      digits    <= digits_nxt;
      blank     <= blank_nxt;
      grant     <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter: a per-cycle vector table for count/prog arbitration,
// then hand sequences for alert blink, ack, re-arm, timeout and async reset.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic        count_req;
  logic [15:0] count_digits;
  logic        prog_req;
  logic [15:0] prog_digits;
  logic        alert_req;
  logic [15:0] alert_digits;
  logic        alert_ack;
  logic [15:0] digits;
  logic        blank;
  logic [2:0]  grant;
  logic        alert_timeout;

  int n_vec = 0;
  int n_err = 0;
  int phase = 0;
  logic tick_en = 1'b0;
  logic last_tick = 1'b0;

  display_arbiter #(
    .HOLD_TICKS(3),
    .BLINK_TICKS(2),
    .ALERT_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick),
    .count_req(count_req),
    .count_digits(count_digits),
    .prog_req(prog_req),
    .prog_digits(prog_digits),
    .alert_req(alert_req),
    .alert_digits(alert_digits),
    .alert_ack(alert_ack),
    .digits(digits),
    .blank(blank),
    .grant(grant),
    .alert_timeout(alert_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cr;
    logic [15:0] cd;
    logic        pr;
    logic [15:0] pd;
    logic        tk;
    logic [2:0]  g;
    logic        b;
    logic [15:0] d;
  } vec_t;

  vec_t vt[21];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock; last_tick records whether the edge just taken saw tick=1.
  task automatic clk1();
    @(posedge clk);
    #1;
    last_tick = tick;
    if (tick_en) begin
      phase = (phase + 1) % 4;
      tick  = (phase == 3);
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 8; k++) begin
      clk1();
      if (last_tick) break;
    end
    if (!last_tick) begin
      n_err++;
      $display("FAIL tick_wait: got no tick expected tick within 8 clk");
    end
  endtask

  task automatic wait_grant(input string nm, input logic [2:0] g, input int budget);
    for (int k = 0; k < budget; k++) begin
      clk1();
      if (grant == g) break;
    end
    check(nm, {13'h0, grant}, {13'h0, g});
  endtask

  logic [5:0] blink_exp;
  logic       ok_flag;
  int         pulses;
  int         ticks;
  int         ticks_at_pulse;

  initial begin
    reset_n      = 1'b0;
    tick         = 1'b0;
    count_req    = 1'b0;
    count_digits = 16'h0000;
    prog_req     = 1'b0;
    prog_digits  = 16'h0000;
    alert_req    = 1'b0;
    alert_digits = 16'hA1A1;
    alert_ack    = 1'b0;

    //           cr  cd        pr  pd        tk   g       b  d
    vt[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 16'h0000};
    vt[1]  = '{1'b1, 16'h0130, 1'b0, 16'h0000, 1'b0, 3'b001, 1'b0, 16'h0000};
    vt[2]  = '{1'b1, 16'h0130, 1'b0, 16'h0000, 1'b0, 3'b001, 1'b0, 16'h0130};
    vt[3]  = '{1'b1, 16'h0131, 1'b0, 16'h0000, 1'b1, 3'b001, 1'b0, 16'h0131};
    vt[4]  = '{1'b1, 16'h0131, 1'b1, 16'h1200, 1'b0, 3'b001, 1'b0, 16'h0131};
    vt[5]  = '{1'b1, 16'h0131, 1'b1, 16'h1200, 1'b1, 3'b001, 1'b0, 16'h0131};
    vt[6]  = '{1'b1, 16'h0131, 1'b1, 16'h1200, 1'b1, 3'b001, 1'b0, 16'h0131};
    vt[7]  = '{1'b1, 16'h0131, 1'b1, 16'h1200, 1'b0, 3'b010, 1'b0, 16'h0131};
    vt[8]  = '{1'b1, 16'h0131, 1'b1, 16'h1200, 1'b0, 3'b010, 1'b0, 16'h1200};
    vt[9]  = '{1'b1, 16'h0131, 1'b0, 16'h1201, 1'b0, 3'b010, 1'b0, 16'h1201};
    vt[10] = '{1'b1, 16'h0131, 1'b0, 16'h1201, 1'b1, 3'b010, 1'b0, 16'h1201};
    vt[11] = '{1'b1, 16'h0131, 1'b0, 16'h1201, 1'b1, 3'b010, 1'b0, 16'h1201};
    vt[12] = '{1'b1, 16'h0131, 1'b0, 16'h1201, 1'b1, 3'b010, 1'b0, 16'h1201};
    vt[13] = '{1'b1, 16'h0131, 1'b0, 16'h1201, 1'b0, 3'b001, 1'b0, 16'h1201};
    vt[14] = '{1'b0, 16'h0131, 1'b0, 16'h1201, 1'b0, 3'b001, 1'b0, 16'h0131};
    vt[15] = '{1'b0, 16'h0131, 1'b0, 16'h1201, 1'b1, 3'b001, 1'b0, 16'h0131};
    vt[16] = '{1'b0, 16'h0131, 1'b0, 16'h1201, 1'b1, 3'b001, 1'b0, 16'h0131};
    vt[17] = '{1'b0, 16'h0131, 1'b0, 16'h1201, 1'b1, 3'b001, 1'b0, 16'h0131};
    vt[18] = '{1'b0, 16'h0131, 1'b0, 16'h1201, 1'b0, 3'b000, 1'b1, 16'h0131};
    vt[19] = '{1'b0, 16'h0131, 1'b0, 16'h1201, 1'b0, 3'b000, 1'b1, 16'h0000};
    vt[20] = '{1'b1, 16'h0131, 1'b1, 16'h1201, 1'b0, 3'b010, 1'b0, 16'h0000};

    #12;
    check("rst_grant", {13'h0, grant}, 16'h0000);
    check("rst_blank", {15'h0, blank}, 16'h0001);
    check("rst_digits", digits, 16'h0000);
    check("rst_timeout", {15'h0, alert_timeout}, 16'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      count_req    = vt[i].cr;
      count_digits = vt[i].cd;
      prog_req     = vt[i].pr;
      prog_digits  = vt[i].pd;
      tick         = vt[i].tk;
      clk1();
      check($sformatf("vec%0d_grant", i), {13'h0, grant}, {13'h0, vt[i].g});
      check($sformatf("vec%0d_blank", i), {15'h0, blank}, {15'h0, vt[i].b});
      check($sformatf("vec%0d_digits", i), digits, vt[i].d);
    end

    // Free-running tick every 4 clocks from here on; state is PROG with both reqs high.
    tick    = 1'b0;
    phase   = 0;
    tick_en = 1'b1;

    alert_req = 1'b1;
    wait_grant("alert_entry", 3'b100, 2);
    check("alert_blank_entry", {15'h0, blank}, 16'h0000);
    blink_exp = 6'b100110;
    for (int t = 0; t < 6; t++) begin
      wait_tick();
      check($sformatf("blink_t%0d", t + 1), {15'h0, blank}, {15'h0, blink_exp[t]});
    end
    check("alert_digits", digits, 16'hA1A1);

    alert_ack = 1'b1;
    clk1();
    alert_ack = 1'b0;
    wait_grant("ack_to_prog", 3'b010, 3);
    check("ack_blank", {15'h0, blank}, 16'h0000);

    ok_flag = 1'b1;
    for (int k = 0; k < 12; k++) begin
      clk1();
      if (grant == 3'b100) ok_flag = 1'b0;
    end
    check("no_reentry_held", {15'h0, ok_flag}, 16'h0001);

    alert_req = 1'b0;
    clk1();
    alert_req = 1'b1;
    wait_grant("rearm_entry", 3'b100, 2);

    prog_req  = 1'b0;
    count_req = 1'b1;
`ifdef DISP_ARB_TIMEOUT_EN
    pulses         = 0;
    ticks          = 0;
    ticks_at_pulse = -1;
    for (int k = 0; k < 100; k++) begin
      clk1();
      if (alert_timeout) begin
        if (pulses == 0) ticks_at_pulse = ticks;
        pulses++;
      end
      if (last_tick && pulses == 0) ticks++;
    end
    check("timeout_pulses", 16'(pulses), 16'd1);
    check("timeout_ticks", 16'(ticks_at_pulse), 16'd10);
    check("timeout_exit", {13'h0, grant}, 16'h0001);
`else
    ok_flag = 1'b1;
    for (int k = 0; k < 400; k++) begin
      clk1();
      if (grant != 3'b100 || alert_timeout) ok_flag = 1'b0;
    end
    check("alert_persist", {15'h0, ok_flag}, 16'h0001);
    alert_ack = 1'b1;
    clk1();
    alert_ack = 1'b0;
    wait_grant("ack_to_count", 3'b001, 3);
`endif

    alert_req = 1'b0;
    clk1();
    alert_req = 1'b1;
    wait_grant("reset_pre_alert", 3'b100, 2);
    count_req = 1'b0;
    prog_req  = 1'b0;
    alert_req = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_grant", {13'h0, grant}, 16'h0000);
    check("async_rst_blank", {15'h0, blank}, 16'h0001);
    check("async_rst_digits", digits, 16'h0000);
    #3;
    reset_n = 1'b1;
    ok_flag = 1'b1;
    for (int k = 0; k < 10; k++) begin
      clk1();
      if (grant != 3'b000 || blank != 1'b1 || digits != 16'h0000) ok_flag = 1'b0;
    end
    check("post_rst_idle", {15'h0, ok_flag}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
